// File: rtl/piso_tx_pkg.sv
// Shared types and line-level constants for the PISO transmit scheduler.
package piso_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic SDO_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
// Zero latency; requesters wait by holding req until their grant appears.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!any_o && req_i[pos[IW-1:0]]) begin
        any_o               = 1'b1;
        idx_o               = pos[IW-1:0];
        gnt_o[pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin shared PISO: ack/start bit one cycle after req is seen, frame W+2 (W+3 with
// PISO_TX_PARITY_EN), back-to-back grants; requesters hold req until ack.
module piso_tx_sched
  import piso_tx_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IW   = $clog2(NREQ),
  localparam int CW   = (W > 1) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              sdo,
  output logic              busy,
  output logic [IW-1:0]     gnt_id,
  output logic              done
);

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            sdo_q, sdo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef PISO_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [W-1:0]    win_word;
  logic            grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign win_word = data[int'(arb_idx)*W +: W];

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    sdo_d   = SDO_IDLE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    grant   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: grant = arb_any;
      START: begin
        state_d = SHIFT;
        sdo_d   = shreg_q[0];
        busy_d  = 1'b1;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        busy_d  = 1'b1;
        if (cnt_q == CW'(W-1)) begin
`ifdef PISO_TX_PARITY_EN
          state_d = PARITY;
          sdo_d   = par_q;
`else
          state_d = STOP;
          sdo_d   = STOP_BIT;
          done_d  = 1'b1;
`endif
        end else begin
          sdo_d = shreg_d[0];
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_d = STOP;
        sdo_d   = STOP_BIT;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end
`endif
      STOP: begin
        if (arb_any) grant = 1'b1;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d = START;
      shreg_d = win_word;
      cnt_d   = '0;
      gnt_d   = arb_idx;
      ack_d   = arb_gnt;
      ptr_d   = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
      sdo_d   = START_BIT;
      busy_d  = 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_d   = ^win_word;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      sdo_q   <= SDO_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign sdo    = sdo_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;
  assign done   = done_q;

endmodule
